// File: rtl/fft_grid_writeback.sv
// FFT grid write-back: maps transformed points from the parallel FFT lanes
// onto the DIMENSION x DIMENSION grid banks for an X, Y or Z pass.
// Grid point (x,y,z) lives in bank[y*DIMENSION+z] at address x.
module fft_grid_writeback #(
    parameter int DIMENSION          = 16,
    parameter int DIMENSION_LOG      = 4,
    parameter int DATA_REAL_WIDTH    = 32,
    parameter int DATA_IMAG_WIDTH    = 32,
    parameter int GRID_ADDRESS_WIDTH = 4,
    parameter int NUM_FFTS           = 4,
    parameter int NUM_FFTS_LOG       = 2
) (
    input  logic                                                               clk,
    input  logic                                                               rst,
    input  logic                                                               start,
    input  logic [2:0]                                                         FFT_dim,
    input  logic                                                               in_valid,
    output logic                                                               in_ready,
    input  logic [NUM_FFTS-1:0]                                                lane_en,
    input  logic [NUM_FFTS*(DATA_REAL_WIDTH+DATA_IMAG_WIDTH+2)-1:0]            FFTData_in,
    output logic                                                               busy,
    output logic                                                               done,
    output logic                                                               err,
    output logic [DIMENSION*DIMENSION-1:0]                                     DATABASE_wren,
    output logic [DIMENSION*DIMENSION*GRID_ADDRESS_WIDTH-1:0]                  DATABASE_writeAddress,
    output logic [DIMENSION*DIMENSION*(DATA_REAL_WIDTH+DATA_IMAG_WIDTH+2)-1:0] DATABASE_dataIn
);

    localparam int WORD   = DATA_REAL_WIDTH + DATA_IMAG_WIDTH + 2;
    localparam int DL     = DIMENSION_LOG;
    localparam int GW     = 2*DIMENSION_LOG - NUM_FFTS_LOG;
    localparam int NBANK  = DIMENSION*DIMENSION;
    localparam int GAW    = GRID_ADDRESS_WIDTH;
    localparam logic [DL-1:0] K_MAX = '1;
    localparam logic [GW-1:0] G_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [DL-1:0]   k_q, k_d;
    logic [GW-1:0]   group_q, group_d;
    logic [2:0]      dim_q, dim_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [NBANK-1:0]      wren_q, wren_d;
    logic [NBANK*GAW-1:0]  addr_q, addr_d;
    logic [NBANK*WORD-1:0] data_q, data_d;

    logic            accept;
    logic            last_beat;
    logic            dim_legal;

    logic [2*DL-1:0] line;
    logic [DL-1:0]   lo, hi, xc, yc, zc;
    logic [2*DL-1:0] bank;

    // in_ready is only ever high in WRITE, so acceptance needs no state term
    assign accept    = in_valid & in_ready_q;
    assign last_beat = accept & (k_q == K_MAX) & (group_q == G_MAX);
    assign dim_legal = (FFT_dim == 3'b001) | (FFT_dim == 3'b010) | (FFT_dim == 3'b100);

    // Next-state, beat/group counters and status outputs
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        group_d = group_q;
        dim_d   = dim_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dim_legal) begin
                        dim_d   = FFT_dim;
                        k_d     = '0;
                        group_d = '0;
                        state_d = ST_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_MAX) group_d = group_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
    end

    // Lane-to-bank mapping for the accepted beat; untargeted banks stay zero
    always_comb begin
        wren_d = '0;
        addr_d = '0;
        data_d = '0;
        line   = '0;
        lo     = '0;
        hi     = '0;
        xc     = '0;
        yc     = '0;
        zc     = '0;
        bank   = '0;
        if (accept) begin
            for (int f = 0; f < NUM_FFTS; f++) begin
                line = {group_q, NUM_FFTS_LOG'(f)};
                lo   = line[DL-1:0];
                hi   = line[2*DL-1:DL];
                case (dim_q)
                    3'b010:  begin zc = lo; xc = hi; yc = k_q; end
                    3'b100:  begin yc = lo; xc = hi; zc = k_q; end
                    default: begin yc = lo; zc = hi; xc = k_q; end
                endcase
                bank = {yc, zc};
                if (lane_en[f]) begin
                    wren_d[bank]                     = 1'b1;
                    addr_d[int'(bank)*GAW +: GAW]    = xc;
                    data_d[int'(bank)*WORD +: WORD]  = FFTData_in[f*WORD +: WORD];
                end
            end
        end
    end

    // Control FSM and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            group_q    <= '0;
            dim_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            group_q    <= group_d;
            dim_q      <= dim_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Registered bank write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wren_q <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign in_ready              = in_ready_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign err                   = err_q;
    assign DATABASE_wren         = wren_q;
    assign DATABASE_writeAddress = addr_q;
    assign DATABASE_dataIn       = data_q;

endmodule
